// File: rtl/simon_pkg.sv
// Shared Simon constants: default datapath widths and the LED mode encodings
// used by both the controller and the datapath.
package simon_pkg;

   localparam int SIMON_PAT_W  = 4;
   localparam int SIMON_ADDR_W = 6;

   localparam logic [2:0] LED_MODE_INPUT    = 3'b001;
   localparam logic [2:0] LED_MODE_PLAYBACK = 3'b010;
   localparam logic [2:0] LED_MODE_REPEAT   = 3'b100;
   localparam logic [2:0] LED_MODE_DONE     = 3'b111;

   function automatic logic is_onehot4(input logic [3:0] v);
      return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
   endfunction

endpackage

// File: rtl/simon_regfile.sv
// Pattern memory: 2**ADDR_W x PAT_W, one synchronous write port, one
// asynchronous read port, whole array cleared by synchronous reset.
module simon_regfile #(
   parameter int PAT_W  = 4,
   parameter int ADDR_W = 6
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_waddr,
   input  logic [PAT_W-1:0]  i_wdata,
   input  logic [ADDR_W-1:0] i_raddr,
   output logic [PAT_W-1:0]  o_rdata
);

   logic [PAT_W-1:0] r_mem [2**ADDR_W];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < 2**ADDR_W; k++) r_mem[k] <= '0;
      end else if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/simon_datapath.sv
// Simon datapath: pattern memory, `last`/`i` counters and status comparators.
// Optional SIMON_SCORE_EN adds a saturating successful-round `score` output.
module simon_datapath
   import simon_pkg::*;
#(
   parameter int PAT_W  = SIMON_PAT_W,
   parameter int ADDR_W = SIMON_ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [PAT_W-1:0]  pattern,
   input  logic              last_inc,
   input  logic              i_inc,
   input  logic              i_clr,
   input  logic              mem_ld,
   input  logic              s_led_eq_pat,
   output logic              i_lt_last,
   output logic              arr_full,
   output logic              correct_pat,
   output logic              legal,
   output logic [PAT_W-1:0]  pattern_leds
`ifdef SIMON_SCORE_EN
   ,
   output logic [ADDR_W:0]   score
`endif
);

   localparam logic [ADDR_W-1:0] IDX_MAX = {ADDR_W{1'b1}};

   logic [ADDR_W-1:0] r_last;
   logic [ADDR_W-1:0] r_i;
   logic [PAT_W-1:0]  w_mem_rd;

   // Write address is the pre-increment `last`, even alongside last_inc.
   simon_regfile #(
      .PAT_W  (PAT_W),
      .ADDR_W (ADDR_W)
   ) u_regfile (
      .clk     (clk),
      .rst     (rst),
      .i_we    (mem_ld),
      .i_waddr (r_last),
      .i_wdata (pattern),
      .i_raddr (r_i),
      .o_rdata (w_mem_rd)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_last <= '0;
      end else if (last_inc && (r_last != IDX_MAX)) begin
         r_last <= r_last + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_i <= '0;
      end else if (i_clr) begin
         r_i <= '0;
      end else if (i_inc && (r_i != IDX_MAX)) begin
         r_i <= r_i + 1'b1;
      end
   end

`ifdef SIMON_SCORE_EN
   localparam logic [ADDR_W:0] SCORE_MAX = {1'b1, {ADDR_W{1'b0}}};
   logic [ADDR_W:0] r_score;

   // i_clr together with mem_ld marks the controller's successful-round step.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_score <= '0;
      end else if (i_clr && mem_ld && (r_score != SCORE_MAX)) begin
         r_score <= r_score + 1'b1;
      end
   end

   assign score = r_score;
`endif

   assign i_lt_last    = (r_i < r_last);
   assign arr_full     = (r_last == IDX_MAX);
   assign correct_pat  = (pattern == w_mem_rd);
   assign legal        = ($countones(pattern) == 1);
   assign pattern_leds = s_led_eq_pat ? pattern : w_mem_rd;

endmodule

// File: tb/tb_simon_datapath.sv
// Directed bench for simon_datapath; covers the score counter when
// SIMON_SCORE_EN is defined.
module tb_simon_datapath;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] pattern;
   logic       last_inc, i_inc, i_clr, mem_ld, s_led_eq_pat;
   logic       i_lt_last, arr_full, correct_pat, legal;
   logic [3:0] pattern_leds;
`ifdef SIMON_SCORE_EN
   logic [6:0] score;
`endif

   int checks   = 0;
   int failures = 0;

   simon_datapath #(.PAT_W(4), .ADDR_W(6)) dut (
      .clk          (clk),
      .rst          (rst),
      .pattern      (pattern),
      .last_inc     (last_inc),
      .i_inc        (i_inc),
      .i_clr        (i_clr),
      .mem_ld       (mem_ld),
      .s_led_eq_pat (s_led_eq_pat),
      .i_lt_last    (i_lt_last),
      .arr_full     (arr_full),
      .correct_pat  (correct_pat),
      .legal        (legal),
      .pattern_leds (pattern_leds)
`ifdef SIMON_SCORE_EN
      ,
      .score        (score)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      rst = 0; last_inc = 0; i_inc = 0; i_clr = 0; mem_ld = 0;
   endtask

   initial begin
      idle();
      s_led_eq_pat = 0;
      pattern = 4'b0100;

      // Reset state
      rst = 1;
      tick();
      rst = 0;
      chk("rst_i_lt_last", i_lt_last, 0);
      chk("rst_arr_full", arr_full, 0);
      chk("rst_leds", pattern_leds, 4'b0000);
      chk("rst_legal", legal, 1);
      chk("rst_correct", correct_pat, 0);
`ifdef SIMON_SCORE_EN
      chk("rst_score", score, 0);
`endif

      // Legal check
      pattern = 4'b0000; #1 chk("legal_0000", legal, 0);
      pattern = 4'b0011; #1 chk("legal_0011", legal, 0);
      pattern = 4'b1000; #1 chk("legal_1000", legal, 1);

      // Load two entries
      pattern = 4'b0010; mem_ld = 1; last_inc = 1; tick();
      pattern = 4'b1000; tick();
      idle();
      i_clr = 1; tick(); idle();
      chk("play0_leds", pattern_leds, 4'b0010);
      chk("play0_lt", i_lt_last, 1);
      i_inc = 1; tick(); idle();
      chk("play1_leds", pattern_leds, 4'b1000);
      chk("play1_lt", i_lt_last, 1);
      i_inc = 1; tick(); idle();
      chk("play2_lt", i_lt_last, 0);
      chk("play2_leds", pattern_leds, 4'b0000);

      // Repeat compare
      i_clr = 1; tick(); idle();
      s_led_eq_pat = 1; pattern = 4'b0010; #1;
      chk("rep_correct", correct_pat, 1);
      chk("rep_leds", pattern_leds, 4'b0010);
      pattern = 4'b0001; #1;
      chk("rep_wrong", correct_pat, 0);
      chk("rep_leds_pat", pattern_leds, 4'b0001);
      s_led_eq_pat = 0;

      // Full boundary: last 2 -> 62, then 63
      last_inc = 1;
      for (int k = 0; k < 60; k++) tick();
      idle();
      chk("full_62", arr_full, 0);
      last_inc = 1; tick(); idle();
      chk("full_63", arr_full, 1);
      pattern = 4'b0100; mem_ld = 1; last_inc = 1; tick(); idle();
      chk("full_stays", arr_full, 1);
      i_clr = 1; tick(); idle();
      i_inc = 1;
      for (int k = 0; k < 62; k++) tick();
      idle();
      chk("i62_lt", i_lt_last, 1);
      chk("mem62_leds", pattern_leds, 4'b0000);
      i_inc = 1; tick(); idle();
      chk("i63_lt", i_lt_last, 0);
      chk("mem63_leds", pattern_leds, 4'b0100);
      i_inc = 1; tick(); idle();
      chk("i_sat_leds", pattern_leds, 4'b0100);

      // Priority: i at 5, clear and increment together
      i_clr = 1; tick(); idle();
      i_inc = 1;
      for (int k = 0; k < 5; k++) tick();
      idle();
      chk("i5_leds", pattern_leds, 4'b0000);
      i_clr = 1; i_inc = 1; tick(); idle();
      chk("prio_leds", pattern_leds, 4'b0010);

      // Reset overrides strobes
      i_inc = 1; tick(); idle();
      pattern = 4'b1000; rst = 1; mem_ld = 1; last_inc = 1; i_inc = 1; tick(); idle();
      chk("rst2_leds", pattern_leds, 4'b0000);
      chk("rst2_full", arr_full, 0);
      chk("rst2_lt", i_lt_last, 0);
      s_led_eq_pat = 1; pattern = 4'b0001; #1;
      chk("pre_wr_correct", correct_pat, 0);
      mem_ld = 1; tick(); idle();
      chk("post_wr_correct", correct_pat, 1);
      chk("post_wr_lt", i_lt_last, 0);
      s_led_eq_pat = 0; #1;
      chk("post_wr_leds", pattern_leds, 4'b0001);

`ifdef SIMON_SCORE_EN
      i_clr = 1; mem_ld = 1; tick(); tick(); idle();
      chk("score_2", score, 2);
      rst = 1; tick(); idle();
      chk("score_rst", score, 0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/simon_datapath.md
Name: simon_datapath

Overview:
- Datapath partner of the Simon control FSM.
- Holds the pattern register file, the `last` (sequence length) and `i` (playback/repeat index) counters, and the comparators.
- Consumes the controller's command strobes and returns the status flags the controller branches on.
- Drives the four pattern LEDs.

Parameters:
- PAT_W, 4, width of one pattern (one switch/LED per bit)
- ADDR_W, 6, register-file address width; depth = 2**ADDR_W = 64 entries

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- pattern  input  PAT_W  current switch pattern
- last_inc  input  1  increment `last`
- i_inc  input  1  increment `i`
- i_clr  input  1  clear `i` to 0
- mem_ld  input  1  write `pattern` into mem[last]
- s_led_eq_pat  input  1  LED source select: 1 = pattern, 0 = mem[i]
- i_lt_last  output  1  (i < last)
- arr_full  output  1  (last == 2**ADDR_W-1)
- correct_pat  output  1  (pattern == mem[i])
- legal  output  1  pattern has exactly one bit set
- pattern_leds  output  PAT_W  s_led_eq_pat ? pattern : mem[i]

Behaviour:
- Clock and reset: one clock `clk`. Reset `rst` is synchronous and active-high.
- Reset (rst=1 at a rising edge):
  - i=0, last=0, all 64 memory entries = 0.
  - Resulting outputs: i_lt_last=0, arr_full=0, correct_pat=(pattern==0), legal per pattern, pattern_leds = s_led_eq_pat ? pattern : 0.
  - rst overrides every strobe in the same cycle.
- Status outputs are purely combinational from registered state and `pattern`, so there is zero-cycle latency to the controller. Memory read is asynchronous at address i.
- mem_ld: at the edge, mem[last] <= pattern. The write address is the pre-increment `last`, even when last_inc is asserted in the same cycle.
- last_inc: last <= last+1. Saturates at 2**ADDR_W-1: no wrap, the write address stays at the final entry.
- i counter:
  - i_clr has priority over i_inc; both asserted -> i=0.
  - i_inc alone -> i <= i+1, saturating at 2**ADDR_W-1.
- Comparisons:
  - i_lt_last is an unsigned compare at ADDR_W bits.
  - legal = popcount(pattern)==1; 4'b0000 and any multi-bit pattern are illegal.
- The datapath does not check strobe legality. Any strobe combination is accepted and each strobe acts independently under the rules above.
- correct_pat reads mem[i] as of the current cycle. A write to mem[i] becomes visible only in the next cycle.

Optional Feature:
- Macro: SIMON_SCORE_EN.
- When defined:
  - Adds output `score` [ADDR_W:0], reset to 0.
  - `score` increments on every cycle where i_clr && mem_ld are both high (the controller's successful-round transition).
  - Saturates at 2**ADDR_W.
- When undefined: port and counter are absent, and the block behaves identically otherwise.

Decomposition:
- Package simon_pkg holds:
  - PAT_W and ADDR_W defaults.
  - LED_MODE_INPUT=3'b001, LED_MODE_PLAYBACK=3'b010, LED_MODE_REPEAT=3'b100, LED_MODE_DONE=3'b111, shared with the controller.
- Sub-module simon_regfile contains the 2**ADDR_W x PAT_W array:
  - one synchronous write port (we, waddr, wdata);
  - one asynchronous read port (raddr, rdata);
  - synchronous clear on rst.
- Counters and comparators stay in simon_datapath.

Test Plan:
- Reset with pattern=4'b0100, s_led_eq_pat=0 -> i_lt_last=0, arr_full=0, pattern_leds=0, legal=1, correct_pat=0.
- Legal check, combinational: pattern 4'b0000 -> legal=0; 4'b0011 -> legal=0; 4'b1000 -> legal=1.
- Load and playback:
  - mem_ld+last_inc with pattern 4'b0010, then 4'b1000 -> last=2.
  - i_clr, then read -> pattern_leds=4'b0010, i_lt_last=1.
  - i_inc -> pattern_leds=4'b1000, i_lt_last=1.
  - i_inc -> i_lt_last=0.
- Repeat compare:
  - i=0, s_led_eq_pat=1, pattern=4'b0010 -> correct_pat=1 and pattern_leds=4'b0010.
  - pattern=4'b0001 -> correct_pat=0.
- Full boundary:
  - 63 cycles of last_inc -> arr_full=1.
  - One more last_inc with mem_ld, pattern=4'b0100 -> last stays 63, mem[63]=4'b0100, arr_full stays 1.
- Priority and reset:
  - i_clr and i_inc together with i=5 -> i=0.
  - rst asserted together with mem_ld and last_inc mid-sequence -> last=0, memory cleared, no write.
  - With SIMON_SCORE_EN: two i_clr&&mem_ld cycles -> score=2, and rst -> score=0.
